// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and size helpers for the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_DATA = 3'd2,
        I_ADDR = 3'd3,
        I_DATA = 3'd4
    } arbState_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Store size follows from the strobe pattern; anything narrower than a half is a byte.
    function automatic logic [1:0] wen2size(input logic [3:0] wen);
        case (wen)
            4'b1111:          return SZ_WORD;
            4'b0011, 4'b1100: return SZ_HALF;
            default:          return SZ_BYTE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Serialises fetch and data requests onto one SRAM-like bus,
//               data side first, and reports per-side stalls to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              ext_stall,
    input  logic              flush_inst,
    output logic              i_stall,
    output logic              d_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arbState_e r_state;
    logic      r_instDone;
    logic      r_dataDone;
    logic      r_instDrop;
    logic      w_cpuStall;
    logic      w_dropFetch;

    assign i_stall     = inst_en & ~r_instDone;
    assign d_stall     = mem_en & ~r_dataDone;
    assign w_cpuStall  = i_stall | d_stall | ext_stall;
    // A flush arriving on the very cycle the fetch returns still discards it.
    assign w_dropFetch = r_instDrop | flush_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_instDone <= 1'b0;
            r_dataDone <= 1'b0;
            r_instDrop <= 1'b0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_size   <= SZ_BYTE;
            bus_addr   <= '0;
            bus_wstrb  <= 4'b0000;
            bus_wdata  <= '0;
            inst_rdata <= '0;
            mem_rdata  <= '0;
        end else begin
            if (!w_cpuStall || flush_inst) begin
                r_instDone <= 1'b0;
            end
            if (!w_cpuStall) begin
                r_dataDone <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (d_stall) begin
                        r_state   <= D_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= |mem_wen;
                        bus_wstrb <= mem_wen;
                        bus_size  <= (|mem_wen) ? wen2size(mem_wen) : mem_size;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (i_stall) begin
                        r_state   <= I_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_wstrb <= 4'b0000;
                        bus_size  <= SZ_WORD;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok) begin
                        r_state <= D_DATA;
                        bus_req <= 1'b0;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        r_state    <= IDLE;
                        r_dataDone <= 1'b1;
                        if (!bus_wr) begin
                            mem_rdata <= bus_rdata;
                        end
                    end
                end
                I_ADDR: begin
                    if (flush_inst) begin
                        r_instDrop <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        r_state <= I_DATA;
                        bus_req <= 1'b0;
                    end
                end
                I_DATA: begin
                    if (bus_data_ok) begin
                        r_state <= IDLE;
                        if (w_dropFetch) begin
                            r_instDrop <= 1'b0;
                        end else begin
                            inst_rdata <= bus_rdata;
                            r_instDone <= 1'b1;
                        end
                    end else if (flush_inst) begin
                        r_instDrop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Randomised and directed self-checking bench for mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en, mem_en, ext_stall, flush_inst;
    logic [31:0] inst_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] inst_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        i_stall, d_stall, bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ext_stall(ext_stall), .flush_inst(flush_inst),
        .i_stall(i_stall), .d_stall(d_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        mIDone, mDDone, mDrop, mTxData;
    int          mPh;                 // 0 = bus free, 1 = waiting addr accept, 2 = waiting completion
    logic        expReq, expWr;
    logic [1:0]  expSize;
    logic [3:0]  expStrb;
    logic [31:0] expAddr, expWdata, expIR, expMR;

    function automatic logic [1:0] refSize(input logic [3:0] wen);
        case (wen)
            4'b1111: refSize = 2'd2;
            4'b0011: refSize = 2'd1;
            4'b1100: refSize = 2'd1;
            default: refSize = 2'd0;
        endcase
    endfunction

    task automatic modelReset();
        mIDone = 0; mDDone = 0; mDrop = 0; mTxData = 0; mPh = 0;
        expReq = 0; expWr = 0; expSize = 0; expStrb = 0;
        expAddr = 0; expWdata = 0; expIR = 0; expMR = 0;
    endtask

    task automatic modelStep();
        logic wantI, wantD, advance;
        wantI   = inst_en && !mIDone;
        wantD   = mem_en && !mDDone;
        advance = !(wantI || wantD || ext_stall);
        if (advance) begin mIDone = 0; mDDone = 0; end
        if (flush_inst) mIDone = 0;
        if (mPh == 0) begin
            if (wantD) begin
                mPh = 1; mTxData = 1; expReq = 1;
                expWr = (mem_wen != 4'b0000); expStrb = mem_wen;
                expSize = expWr ? refSize(mem_wen) : mem_size;
                expAddr = mem_addr; expWdata = mem_wdata;
            end else if (wantI) begin
                mPh = 1; mTxData = 0; expReq = 1;
                expWr = 0; expStrb = 4'b0000; expSize = 2'd2;
                expAddr = inst_addr; expWdata = 0;
            end
        end else begin
            if (flush_inst && !mTxData) mDrop = 1;
            if (mPh == 1 && bus_addr_ok) begin
                mPh = 2; expReq = 0;
            end else if (mPh == 2 && bus_data_ok) begin
                mPh = 0;
                if (mTxData) begin
                    if (!expWr) expMR = bus_rdata;
                    mDDone = 1;
                end else if (mDrop) begin
                    mDrop = 0;
                end else begin
                    expIR = bus_rdata; mIDone = 1;
                end
            end
        end
    endtask

    task automatic checkOutputs();
        chk("bus_req", bus_req, expReq);
        if (expReq) begin
            chk("bus_addr", bus_addr, expAddr);
            chk("bus_wr", bus_wr, expWr);
            chk("bus_size", bus_size, expSize);
            chk("bus_wstrb", bus_wstrb, expStrb);
            if (expWr) chk("bus_wdata", bus_wdata, expWdata);
        end
        chk("i_stall", i_stall, inst_en && !mIDone);
        chk("d_stall", d_stall, mem_en && !mDDone);
        chk("inst_rdata", inst_rdata, expIR);
        chk("mem_rdata", mem_rdata, expMR);
    endtask

    // ---------------- bus responder ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txRec_t;
    txRec_t      txLog[$];
    logic        rPhData = 0, rndMode = 0;
    int          rCnt = 0, addrWait = 0, dataWait = 0, doneCnt = 0;
    logic [31:0] rdVal = 0;

    task automatic respond();
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = $urandom;
        if (!rPhData) begin
            if (bus_req) begin
                if (rCnt >= addrWait) begin
                    bus_addr_ok = 1; rPhData = 1; rCnt = 0;
                    txLog.push_back('{bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata});
                end else rCnt++;
            end
        end else if (rCnt >= dataWait) begin
            bus_data_ok = 1; rPhData = 0; rCnt = 0; doneCnt++;
            bus_rdata = rndMode ? $urandom : rdVal;
            if (rndMode) begin
                addrWait = $urandom_range(0, 3);
                dataWait = $urandom_range(0, 3);
            end
        end else rCnt++;
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutputs();
        respond();
    endtask

    // Runs until both stalls drop; returns per-side stall lengths and req cycles.
    task automatic runReq(input int maxCyc, output int iCyc, output int dCyc,
                          output int reqCyc, output logic dFellFirst);
        logic prevD;
        #1;
        iCyc = 0; dCyc = 0; reqCyc = 0; dFellFirst = 0;
        for (int k = 0; k < maxCyc && (i_stall || d_stall); k++) begin
            if (i_stall) iCyc++;
            if (d_stall) dCyc++;
            prevD = d_stall;
            cycle();
            if (bus_req) reqCyc++;
            if (prevD && !d_stall && i_stall) dFellFirst = 1;
        end
        chk("stall_timeout", {62'd0, i_stall, d_stall}, 64'd0);
        inst_en = 0; mem_en = 0;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0]  wenTab [9] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    int          ic, dc, rc;
    logic        dFirst, advNow;
    logic [31:0] prevIR;
    int          startCnt;

    initial begin
        rst = 0; inst_en = 0; mem_en = 0; ext_stall = 0; flush_inst = 0;
        inst_addr = 0; mem_addr = 0; mem_wdata = 0; mem_wen = 0; mem_size = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("reset_bus_req", bus_req, 0);
        chk("reset_inst_rdata", inst_rdata, 0);
        chk("reset_mem_rdata", mem_rdata, 0);
        chk("reset_i_stall", i_stall, 0);

        // fetch only, zero wait states
        txLog.delete(); rdVal = 32'h24010001;
        inst_en = 1; inst_addr = 32'hBFC00000;
        runReq(20, ic, dc, rc, dFirst);
        chk("fetch0_stall_len", ic, 3);
        chk("fetch0_req_cycles", rc, 1);
        chk("fetch0_rdata", inst_rdata, 32'h24010001);
        chk("fetch0_tx_count", txLog.size(), 1);
        if (txLog.size() >= 1) begin
            chk("fetch0_addr", txLog[0].addr, 32'hBFC00000);
            chk("fetch0_size", txLog[0].size, 2);
        end

        // simultaneous fetch and sw
        txLog.delete(); rdVal = 32'h00000013;
        inst_en = 1; inst_addr = 32'hBFC00004;
        mem_en = 1; mem_wen = 4'b1111; mem_addr = 32'h80000010; mem_wdata = 32'hDEADBEEF;
        runReq(40, ic, dc, rc, dFirst);
        chk("sw_d_before_i", dFirst, 1);
        chk("sw_tx_count", txLog.size(), 2);
        if (txLog.size() >= 2) begin
            chk("sw_first_wr", txLog[0].wr, 1);
            chk("sw_first_strb", txLog[0].strb, 4'hF);
            chk("sw_first_size", txLog[0].size, 2);
            chk("sw_first_wdata", txLog[0].wdata, 32'hDEADBEEF);
            chk("sw_second_addr", txLog[1].addr, 32'hBFC00004);
            chk("sw_second_wr", txLog[1].wr, 0);
        end

        // sb and sh sizes
        txLog.delete();
        mem_en = 1; mem_wen = 4'b1000; mem_addr = 32'h80000023; mem_wdata = 32'h11000000;
        runReq(20, ic, dc, rc, dFirst);
        mem_en = 1; mem_wen = 4'b1100; mem_addr = 32'h80000022; mem_wdata = 32'h22330000;
        runReq(20, ic, dc, rc, dFirst);
        chk("sbsh_tx_count", txLog.size(), 2);
        if (txLog.size() >= 2) begin
            chk("sb_size", txLog[0].size, 0);
            chk("sb_strb", txLog[0].strb, 4'b1000);
            chk("sh_size", txLog[1].size, 1);
        end

        // delayed addr_ok (4) and data_ok (2)
        addrWait = 4; dataWait = 2; rdVal = 32'h3C1D0000;
        inst_en = 1; inst_addr = 32'hBFC00100;
        runReq(40, ic, dc, rc, dFirst);
        chk("slow_req_cycles", rc, 5);
        chk("slow_stall_len", ic, 9);
        chk("slow_rdata", inst_rdata, 32'h3C1D0000);

        // flush during the fetch completion wait
        txLog.delete(); addrWait = 0; dataWait = 3; rdVal = 32'h11111111;
        prevIR = inst_rdata; startCnt = doneCnt;
        inst_en = 1; inst_addr = 32'hBFC00200;
        cycle(); cycle();
        flush_inst = 1; inst_addr = 32'hBFC00300;
        cycle();
        flush_inst = 0;
        for (int k = 0; k < 20 && doneCnt == startCnt; k++) cycle();
        rdVal = 32'h22222222;
        cycle();
        chk("flush_rdata_kept", inst_rdata, prevIR);
        chk("flush_still_stalled", i_stall, 1);
        runReq(40, ic, dc, rc, dFirst);
        chk("flush_tx_count", txLog.size(), 2);
        if (txLog.size() >= 2) chk("flush_refetch_addr", txLog[1].addr, 32'hBFC00300);
        chk("flush_new_rdata", inst_rdata, 32'h22222222);

        // randomized traffic
        rndMode = 1; txLog.delete();
        for (int n = 0; n < 1500; n++) begin
            advNow = !((inst_en && !mIDone) || (mem_en && !mDDone) || ext_stall);
            cycle();
            flush_inst = 0;
            if (advNow) begin
                inst_en   = ($urandom_range(0, 3) != 0);
                inst_addr = {$urandom} & 32'hFFFF_FFFC;
                mem_en    = ($urandom_range(0, 1) == 0);
                mem_wen   = wenTab[$urandom_range(0, 8)];
                mem_size  = 2'($urandom_range(0, 2));
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            ext_stall = ($urandom_range(0, 4) == 0);
            if (inst_en && !bus_data_ok && $urandom_range(0, 19) == 0) begin
                flush_inst = 1;
                inst_addr  = {$urandom} & 32'hFFFF_FFFC;
            end
        end
        inst_en = 0; mem_en = 0; ext_stall = 0; flush_inst = 0;
        for (int k = 0; k < 30 && mPh != 0; k++) cycle();
        cycle();
        chk("drain_bus_free", bus_req, 0);

        // asynchronous reset while in the data completion wait
        rndMode = 0; addrWait = 0; dataWait = 6;
        mem_en = 1; mem_wen = 4'b0000; mem_size = 2'd2;
        mem_addr = 32'h80000040; mem_wdata = 32'hCAFEF00D;
        cycle(); cycle(); cycle();
        #2 rst = 0;
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_wr", bus_wr, 0);
        chk("rst_bus_size", bus_size, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        mem_en = 0; bus_addr_ok = 0; bus_data_ok = 0;
        rPhData = 0; rCnt = 0; dataWait = 0;
        modelReset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        txLog.delete(); rdVal = 32'h8C220004;
        inst_en = 1; inst_addr = 32'hBFC00400;
        runReq(20, ic, dc, rc, dFirst);
        chk("post_rst_stall_len", ic, 3);
        chk("post_rst_req_cycles", rc, 1);
        chk("post_rst_rdata", inst_rdata, 32'h8C220004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
